// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: 5-stage pipeline control for stage valids, enables, stalls, halt and memory timeout
module pipeline_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetchValid,
  input  logic              hazardStall,
  input  logic              branchTaken,
  input  logic              memAccess,
  input  logic              memReady,
  input  logic              haltWB,
  input  logic              resume,
  output logic              pcEnable,
  output logic              ifidEnable,
  output logic              idexEnable,
  output logic              exmemEnable,
  output logic              memwbEnable,
  output logic              ifidFlush,
  output logic              idexBubble,
  output logic              validID,
  output logic              validEX,
  output logic              validMEM,
  output logic              validWB,
  output logic              halted,
  output logic              memError,
  output logic [PERF_W-1:0] stallCycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;
  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [3:0]        valid_q, valid_d;
  logic              err_q, err_d, halted_q, halted_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              mem_stall, br, hz, hlt, go, frz, take_br, take_hz;
  // valid_q bit 0 is ID, bit 3 is WB
  always_comb begin
    mem_stall = valid_q[2] & memAccess & ~memReady;
    br = valid_q[1] & branchTaken;
    hz = valid_q[0] & hazardStall;
    hlt = valid_q[3] & haltWB;
    go = (state_q == RUN) | ((state_q == MEMWAIT) & memReady);
    frz = ~go | hlt | ((state_q == RUN) & mem_stall);
    take_br = ~frz & br;
    take_hz = ~frz & ~br & hz;
    pcEnable = ~frz & ~take_hz;
    ifidEnable = pcEnable;
    idexEnable = ~frz;
    exmemEnable = ~frz;
    memwbEnable = ~frz;
    ifidFlush = take_br;
    idexBubble = take_br | take_hz;
  end
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    err_d = err_q;
    valid_d[0] = ifidEnable ? fetchValid & ~ifidFlush : valid_q[0];
    valid_d[1] = idexEnable ? valid_q[0] & ~idexBubble : valid_q[1];
    valid_d[2] = exmemEnable ? valid_q[1] : valid_q[2];
    valid_d[3] = memwbEnable ? valid_q[2] : valid_q[3];
    stall_d = (~pcEnable & (state_q != HALTED) & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    case (state_q)
      RUN: begin
        if (hlt) state_d = HALTED;
        else if (mem_stall) begin
          state_d = MEMWAIT;
          wait_d = WW'(1);
        end
      end
      MEMWAIT: begin
        if (memReady) begin
          state_d = hlt ? HALTED : RUN;
          wait_d = '0;
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = HALTED;
          wait_d = '0;
        end else wait_d = wait_q + 1'b1;
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
          err_d = 1'b0;
          valid_d[3] = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    halted_d = state_d == HALTED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q <= '0;
      valid_q <= '0;
      err_q <= 1'b0;
      halted_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      valid_q <= valid_d;
      err_q <= err_d;
      halted_q <= halted_d;
      stall_q <= stall_d;
    end
  end
  assign validID = valid_q[0];
  assign validEX = valid_q[1];
  assign validMEM = valid_q[2];
  assign validWB = valid_q[3];
  assign halted = halted_q;
  assign memError = err_q;
  assign stallCycles = stall_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: vector table, directed corner sequences and random reference-model check
module tb_pipeline_sequencer;
  localparam int N = 4;
  localparam int PW = 5;
  localparam int ADV = 0, HZ = 1, BR = 2, FRZ = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic fetchValid = 1'b0, hazardStall = 1'b0, branchTaken = 1'b0, memAccess = 1'b0;
  logic memReady = 1'b0, haltWB = 1'b0, resume = 1'b0;
  logic pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable, ifidFlush, idexBubble;
  logic validID, validEX, validMEM, validWB, halted, memError;
  logic [PW-1:0] stallCycles;
  logic [17:0] obs;
  int checks = 0, failures = 0;
  pipeline_sequencer #(.MEM_TIMEOUT(N), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .fetchValid(fetchValid), .hazardStall(hazardStall),
    .branchTaken(branchTaken), .memAccess(memAccess), .memReady(memReady), .haltWB(haltWB),
    .resume(resume), .pcEnable(pcEnable), .ifidEnable(ifidEnable), .idexEnable(idexEnable),
    .exmemEnable(exmemEnable), .memwbEnable(memwbEnable), .ifidFlush(ifidFlush),
    .idexBubble(idexBubble), .validID(validID), .validEX(validEX), .validMEM(validMEM),
    .validWB(validWB), .halted(halted), .memError(memError), .stallCycles(stallCycles)
  );
  always #5 clk = ~clk;
  assign obs = {pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable, ifidFlush, idexBubble,
                validID, validEX, validMEM, validWB, halted, memError, stallCycles};
  typedef struct {
    logic [6:0] in;
    logic [4:0] en;
    logic       fl;
    logic       bb;
    logic [3:0] v;
    logic       h;
    logic       e;
    logic [4:0] st;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [6:0] in);
    {fetchValid, hazardStall, branchTaken, memAccess, memReady, haltWB, resume} = in;
  endtask
  task automatic step(input logic [6:0] in);
    @(negedge clk);
    drive(in);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(7'b0000000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(obs), 32'({5'b11111, 2'b00, 4'b0000, 2'b00, 5'd0}));
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  int mode, mwait, mstall, act;
  bit merr, hlt, ms, brq, hzq, pc, adv, b;
  bit [3:0] mv;
  logic [6:0] rin;
  logic [17:0] exp;
  initial begin
    // inputs {fv,hz,br,ma,mr,hw,rs}; valids {ID,EX,MEM,WB}
    tbl[0]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 5'd0};
    tbl[2]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0, 5'd0};
    tbl[3]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 5'd0};
    tbl[4]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 5'd0};
    tbl[5]  = '{7'b1100000, 5'b00111, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, 5'd1};
    tbl[7]  = '{7'b1110000, 5'b11111, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0, 5'd1};
    tbl[8]  = '{7'b1001000, 5'b00000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 5'd1};
    tbl[9]  = '{7'b1001000, 5'b00000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 5'd2};
    tbl[10] = '{7'b1001000, 5'b00000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 5'd3};
    tbl[11] = '{7'b1001100, 5'b11111, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 5'd4};
    tbl[12] = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 5'd4};
    tbl[13] = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b0, 5'd4};
    tbl[14] = '{7'b1000000, 5'b11111, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0, 5'd4};
    tbl[15] = '{7'b1000010, 5'b00000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 5'd4};
    tbl[16] = '{7'b1000010, 5'b00000, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 5'd5};
    tbl[17] = '{7'b1000010, 5'b00000, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 5'd5};
    #12;
    rst_n = 1'b1;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d", i), 32'(obs),
          32'({tbl[i].en, tbl[i].fl, tbl[i].bb, tbl[i].v, tbl[i].h, tbl[i].e, tbl[i].st}));
    end
    do_reset();
    repeat (4) step(7'b1000000);
    step(7'b0001000);
    chk("to_full_pipe", 32'({validID, validEX, validMEM, validWB}), 32'(4'b1111));
    chk("to_freeze_pc", 32'(pcEnable), 32'(0));
    step(7'b0001000);
    step(7'b0001000);
    step(7'b0001000);
    chk("to_no_err_yet", 32'(memError), 32'(0));
    step(7'b0001000);
    chk("to_err", 32'(memError), 32'(1));
    chk("to_halted", 32'(halted), 32'(1));
    chk("to_stalls", 32'(stallCycles), 32'(4));
    step(7'b0000001);
    chk("to_resume_cycle", 32'(halted), 32'(1));
    step(7'b0000000);
    chk("resume_run", 32'({halted, memError}), 32'(0));
    chk("resume_valids", 32'({validID, validEX, validMEM, validWB}), 32'(4'b1110));
    step(7'b0001000);
    step(7'b0001000);
    step(7'b0001000);
    step(7'b0001100);
    chk("ready_at_n_enables", 32'({pcEnable, idexEnable, memwbEnable}), 32'(3'b111));
    step(7'b0000000);
    chk("ready_at_n_no_err", 32'({halted, memError}), 32'(0));
    chk("ready_at_n_stalls", 32'(stallCycles), 32'(7));
    do_reset();
    step(7'b1000000);
    repeat (40) step(7'b0100000);
    chk("sat_pc", 32'(pcEnable), 32'(0));
    chk("sat_count", 32'(stallCycles), 32'(31));
    do_reset();
    mode = 0; mwait = 0; mstall = 0; merr = 1'b0; mv = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      rin = {$urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) == 0};
      step(rin);
      hlt = mv[3] && rin[1];
      ms = mv[2] && rin[3] && !rin[2];
      brq = mv[1] && rin[4];
      hzq = mv[0] && rin[5];
      if (mode == 2 || (mode == 1 && !rin[2]) || hlt || (mode == 0 && ms)) act = FRZ;
      else act = brq ? BR : hzq ? HZ : ADV;
      pc = act == ADV || act == BR;
      adv = act != FRZ;
      b = act == BR;
      exp = {pc, pc, adv, adv, adv, b, b || act == HZ, mv[0], mv[1], mv[2], mv[3],
             mode == 2, merr, 5'(mstall)};
      chk($sformatf("rand%0d", c), 32'(obs), 32'(exp));
      if (!pc && mode != 2 && mstall < 31) mstall++;
      if (act == ADV || act == BR) mv = {mv[2], mv[1], mv[0] & ~b, rin[6] & ~b};
      else if (act == HZ) mv = {mv[2], mv[1], 1'b0, mv[0]};
      if (mode == 2) begin
        if (rin[0]) begin
          mode = 0;
          merr = 1'b0;
          mv[3] = 1'b0;
        end
      end else if (mode == 1 && !rin[2]) begin
        mwait++;
        if (mwait == N) begin
          merr = 1'b1;
          mode = 2;
        end
      end else if (hlt) mode = 2;
      else if (mode == 0 && ms) begin
        mode = 1;
        mwait = 1;
      end else mode = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline control unit for the 5-stage core (IF, ID, EX, MEM, WB). It owns per-stage valid bits and produces every stage-register enable, bubble and flush from four event sources:
- the operand-forwarding hazard stall;
- taken branches resolved in EX;
- data-memory wait states in MEM;
- the halt instruction reaching WB.

It also provides a memory-wait timeout and a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max consecutive memory-wait cycles before error; ≥2.
- PERF_W, 16: width of stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- fetchValid  in  1  IF holds a valid instruction this cycle.
- hazardStall  in  1  combinational stall from forwarding logic, for the instruction in ID.
- branchTaken  in  1  EX instruction is a taken branch; meaningful only when EX valid.
- memAccess  in  1  MEM instruction is a load/store; meaningful only when MEM valid.
- memReady  in  1  data memory completes the access this cycle.
- haltWB  in  1  WB instruction is a halt; meaningful only when WB valid.
- resume  in  1  leave HALTED; ignored in other states.
- pcEnable  out  1  PC register loads next PC or branch target.
- ifidEnable, idexEnable, exmemEnable, memwbEnable  out  1 each  stage register load enables.
- ifidFlush  out  1  IF/ID loads a bubble (valid=0).
- idexBubble  out  1  ID/EX loads a bubble (valid=0).
- validID, validEX, validMEM, validWB  out  1 each  per-stage valid bits (registered).
- halted  out  1  state == HALTED.
- memError  out  1  sticky; set on memory-wait timeout.
- stallCycles  out  PERF_W  saturating count of cycles with pcEnable=0 outside HALTED.

## Operation
- FSM states: RUN, MEMWAIT, HALTED. Enables, flush and bubble are combinational from state and the qualified inputs. Valid bits, state, counters and memError are registers.
- Qualified events:
  - memStall = validMEM & memAccess & ~memReady
  - br = validEX & branchTaken
  - hz = validID & hazardStall
  - hlt = validWB & haltWB
- Priority in RUN, highest first: hlt, memStall, br, hz, normal.
- hlt: all enables 0. Next state HALTED. The halt instruction is not retired further.
- memStall: all enables 0; the whole pipe freezes. Next state MEMWAIT. Wait counter loads 1.
- br: all enables 1, ifidFlush=1, idexBubble=1. This squashes the two younger instructions; the PC loads the target.
- hz: pcEnable=ifidEnable=0, idexBubble=1, idexEnable=1, and all older stages advance.
- normal: all enables 1, no flush or bubble.
- MEMWAIT: all enables 0 while ~memReady, and the counter increments.
  - If memReady: apply RUN rules for this cycle. memStall is treated as 0; br and hz are still honoured. Next state RUN.
  - If the counter reaches MEM_TIMEOUT with ~memReady: set memError, next state HALTED.
- HALTED: all enables 0. On resume, clear memError, invalidate the WB stage, and go to RUN. Stages ID, EX and MEM keep their contents.
- Valid bit update when a stage register enable is 1:
  - validID ← fetchValid & ~ifidFlush
  - validEX ← validID & ~idexBubble
  - validMEM ← validEX
  - validWB ← validMEM
- A disabled stage holds its valid bit.
- stallCycles increments when pcEnable=0 and state≠HALTED. It saturates at all-ones.

## Timing
- Reset values (async, immediate):
  - state RUN.
  - validID, validEX, validMEM, validWB = 0.
  - memError = 0, stallCycles = 0, wait counter = 0.
  - halted = 0.
  - Enables follow RUN/normal rules (pcEnable=1, all stage enables 1, flush/bubble 0).
- Latency:
  - Hazard stall costs exactly 1 cycle per hz assertion.
  - Taken branch costs 2 squashed slots and no freeze cycles.
  - Memory access with memReady in the same cycle costs 0 stall cycles. Each ~memReady cycle adds 1.
- Simultaneous events:
  - hz + br in the same cycle: br wins. The hazarded ID instruction is squashed; no stall cycle.
  - memStall + br: freeze wins. br is re-evaluated on the cycle memReady arrives, since EX held its instruction.
  - hlt + anything: halt wins.
- Reset during MEMWAIT or HALTED returns to RUN with an empty pipe. memError is cleared.
- Timeout boundary: with MEM_TIMEOUT=N, memError rises on the edge after the Nth consecutive ~memReady cycle. It does not rise if memReady arrives in cycle N.

## Test plan
- Reset then 5 cycles of fetchValid=1, no events: valid bits fill to 1111 by cycle 4, all enables 1, stallCycles=0.
- hz=1 for one cycle with full pipe: pcEnable=ifidEnable=0, idexBubble=1 that cycle. validEX=0 the next cycle. stallCycles=1.
- br=1 and hz=1 together: ifidFlush=1, idexBubble=1, pcEnable=1. Next cycle validID=0 and validEX=0. stallCycles unchanged.
- memAccess with memReady low for 3 cycles, then high: enables 0 for 3 cycles, state MEMWAIT, stallCycles=3. The pipe advances on the ready cycle.
- MEM_TIMEOUT=4, memReady stuck low: memError=1 and halted=1 after 4 wait cycles. resume → RUN, memError=0, validWB=0.
- haltWB with validWB=1 → halted=1, enables 0, stallCycles frozen. Async rst_n pulse mid-HALTED → RUN, all valid bits 0.
